pc_seq_ras: RTL and testbench

//  Parametrised program-counter sequencer for the fetch stage. It generalises
//  the fixed 10-bit PC with a configurable PC width, branch-offset width and

---
 rtl/pc_seq_ras.sv | 148 ++++++++++++++
 tb/tb_pc_seq_ras.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_seq_ras.sv
`default_nettype none
// ============================================================================
//  Module   : pc_seq_ras
//  Purpose  : Fetch-stage program-counter sequencer. Supports increment,
//             relative branch, absolute jump, call/return through an internal
//             return-address stack (RAS), fetch stall, synchronous restart,
//             halt detection and fault detection.
//  Ports    : CLK        - clock, rising edge
//             init_n     - asynchronous active-low reset
//             restart    - synchronous restart (PC=0, RAS emptied, RUN)
//             stall      - hold all state this cycle
//             branch_en  - relative branch, bSIGN selects PC-/PC+ bOFFSET
//             bSIGN      - 1: subtract offset, 0: add offset
//             bOFFSET    - unsigned branch offset magnitude
//             jump_en    - absolute jump to jump_tgt
//             call_en    - push PC+1, go to jump_tgt
//             ret_en     - pop top RAS entry into PC
//             jump_tgt   - jump/call target
//             PC         - current fetch address (registered)
//             halt       - high while HALTED
//             fault      - high while FAULT
//             ras_cnt    - number of valid RAS entries
//  Revision : 1.0 - initial release
// ============================================================================
module pc_seq_ras #(
    parameter int PC_W      = 10,
    parameter int OFF_W     = 4,
    parameter int HALT_PC   = 63,
    parameter int RAS_DEPTH = 4
) (
    input  logic                             CLK,
    input  logic                             init_n,
    input  logic                             restart,
    input  logic                             stall,
    input  logic                             branch_en,
    input  logic                             bSIGN,
    input  logic [OFF_W-1:0]                 bOFFSET,
    input  logic                             jump_en,
    input  logic                             call_en,
    input  logic                             ret_en,
    input  logic [PC_W-1:0]                  jump_tgt,
    output logic [PC_W-1:0]                  PC,
    output logic                             halt,
    output logic                             fault,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_cnt
);

    localparam int CNT_W     = $clog2(RAS_DEPTH + 1);
    // Stack index width; at least one bit so a single-entry stack still works.
    localparam int IDX_W     = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int RAS_SLOTS = 1 << IDX_W;

    localparam logic [PC_W-1:0]  c_halt_pc   = PC_W'(HALT_PC);
    localparam logic [CNT_W-1:0] c_ras_depth = CNT_W'(RAS_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;

    state_t             r_state;
    logic [PC_W-1:0]    r_pc;
    logic [CNT_W-1:0]   r_cnt;
    logic [PC_W-1:0]    r_ras [0:RAS_SLOTS-1];

    state_t             w_state_nx;
    logic [PC_W-1:0]    w_pc_nx;
    logic [CNT_W-1:0]   w_cnt_nx;
    logic               w_push;
    logic [IDX_W-1:0]   w_top_idx;
    logic [IDX_W-1:0]   w_push_idx;
    logic [PC_W-1:0]    w_off_ext;
    logic [PC_W-1:0]    w_ret_addr;

    assign w_top_idx  = IDX_W'(r_cnt - 1'b1);
    assign w_push_idx = IDX_W'(r_cnt);
    assign w_off_ext  = PC_W'(bOFFSET);
    assign w_ret_addr = r_pc + 1'b1;

    // Next-state / next-PC selection in priority order.
    always_comb begin
        w_state_nx = r_state;
        w_pc_nx    = r_pc;
        w_cnt_nx   = r_cnt;
        w_push     = 1'b0;

        if (restart) begin
            w_state_nx = ST_RUN;
            w_pc_nx    = '0;
            w_cnt_nx   = '0;
        end else if (!stall && r_state == ST_RUN) begin
            if (r_pc > c_halt_pc) begin
                w_state_nx = ST_HALTED;
            end else if (call_en && ret_en) begin
                w_state_nx = ST_FAULT;
            end else if (ret_en) begin
                if (r_cnt != '0) begin
                    w_pc_nx  = r_ras[w_top_idx];
                    w_cnt_nx = r_cnt - 1'b1;
                end else begin
                    w_state_nx = ST_FAULT;
                end
            end else if (call_en) begin
                if (r_cnt < c_ras_depth) begin
                    w_push   = 1'b1;
                    w_pc_nx  = jump_tgt;
                    w_cnt_nx = r_cnt + 1'b1;
                end else begin
                    w_state_nx = ST_FAULT;
                end
            end else if (jump_en) begin
                w_pc_nx = jump_tgt;
            end else if (branch_en) begin
                // Both directions wrap naturally at PC_W bits.
                w_pc_nx = bSIGN ? (r_pc - w_off_ext) : (r_pc + w_off_ext);
            end else begin
                w_pc_nx = r_pc + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge init_n) begin
        if (!init_n) begin
            r_state <= ST_RUN;
            r_pc    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_pc    <= w_pc_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Stack contents are only meaningful below r_cnt, so they need no reset.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_ras[w_push_idx] <= w_ret_addr;
        end
    end

    assign PC      = r_pc;
    assign halt    = (r_state == ST_HALTED);
    assign fault   = (r_state == ST_FAULT);
    assign ras_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_seq_ras.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_seq_ras
//  Purpose  : Self-checking bench for pc_seq_ras: directed scenarios followed
//             by randomized traffic, all compared against a queue-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_seq_ras;

    localparam int PC_W      = 10;
    localparam int OFF_W     = 4;
    localparam int HALT_PC   = 63;
    localparam int RAS_DEPTH = 4;
    localparam int CNT_W     = $clog2(RAS_DEPTH + 1);
    localparam int MOD       = 1 << PC_W;

    logic               CLK;
    logic               init_n;
    logic               restart;
    logic               stall;
    logic               branch_en;
    logic               bSIGN;
    logic [OFF_W-1:0]   bOFFSET;
    logic               jump_en;
    logic               call_en;
    logic               ret_en;
    logic [PC_W-1:0]    jump_tgt;
    logic [PC_W-1:0]    PC;
    logic               halt;
    logic               fault;
    logic [CNT_W-1:0]   ras_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_pc;
    int m_stack[$];
    bit m_halt;
    bit m_fault;

    pc_seq_ras #(
        .PC_W     (PC_W),
        .OFF_W    (OFF_W),
        .HALT_PC  (HALT_PC),
        .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .CLK      (CLK),
        .init_n   (init_n),
        .restart  (restart),
        .stall    (stall),
        .branch_en(branch_en),
        .bSIGN    (bSIGN),
        .bOFFSET  (bOFFSET),
        .jump_en  (jump_en),
        .call_en  (call_en),
        .ret_en   (ret_en),
        .jump_tgt (jump_tgt),
        .PC       (PC),
        .halt     (halt),
        .fault    (fault),
        .ras_cnt  (ras_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 0;
        m_stack.delete();
        m_halt  = 0;
        m_fault = 0;
    endtask

    // One clock of the sequencer, written straight from the behavioural rules.
    task automatic model_step();
        if (restart) begin
            model_reset();
        end else if (stall || m_halt || m_fault) begin
            // nothing changes
        end else if (m_pc > HALT_PC) begin
            m_halt = 1;
        end else if (call_en && ret_en) begin
            m_fault = 1;
        end else if (ret_en) begin
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
            else                    m_fault = 1;
        end else if (call_en) begin
            if (m_stack.size() < RAS_DEPTH) begin
                m_stack.push_back((m_pc + 1) % MOD);
                m_pc = int'(jump_tgt);
            end else begin
                m_fault = 1;
            end
        end else if (jump_en) begin
            m_pc = int'(jump_tgt);
        end else if (branch_en) begin
            if (bSIGN) m_pc = ((m_pc - int'(bOFFSET)) % MOD + MOD) % MOD;
            else       m_pc = (m_pc + int'(bOFFSET)) % MOD;
        end else begin
            m_pc = (m_pc + 1) % MOD;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".pc"},    int'(PC),      m_pc);
        check({tag, ".halt"},  int'(halt),    int'(m_halt));
        check({tag, ".fault"}, int'(fault),   int'(m_fault));
        check({tag, ".cnt"},   int'(ras_cnt), m_stack.size());
    endtask

    task automatic idle_inputs();
        restart   = 1'b0;
        stall     = 1'b0;
        branch_en = 1'b0;
        bSIGN     = 1'b0;
        bOFFSET   = '0;
        jump_en   = 1'b0;
        call_en   = 1'b0;
        ret_en    = 1'b0;
        jump_tgt  = '0;
    endtask

    // Apply current inputs for one edge, then compare just after it.
    task automatic step(input string tag);
        @(posedge CLK);
        model_step();
        #1;
        compare_all(tag);
        idle_inputs();
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step("restart");
    endtask

    initial begin
        idle_inputs();
        init_n = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        compare_all("reset");
        @(negedge CLK);
        init_n = 1'b1;

        // Free run to halt
        for (int i = 1; i <= 64; i++) step("run");
        check("run.pc64", int'(PC), 64);
        check("run.nohalt64", int'(halt), 0);
        step("halt_entry");
        check("halt.flag", int'(halt), 1);
        check("halt.pc", int'(PC), 64);
        branch_en = 1'b1; bSIGN = 1'b1; bOFFSET = 4'd5;
        step("halt_hold");
        check("halt.hold_pc", int'(PC), 64);

        // Relative branches
        do_restart();
        for (int i = 0; i < 10; i++) step("to10");
        branch_en = 1'b1; bSIGN = 1'b1; bOFFSET = 4'd3;
        step("br_back");
        check("br_back.pc", int'(PC), 7);
        branch_en = 1'b1; bSIGN = 1'b0; bOFFSET = 4'd15;
        step("br_fwd");
        check("br_fwd.pc", int'(PC), 22);

        // Wrap below zero lands above HALT_PC, halt follows next cycle
        do_restart();
        branch_en = 1'b1; bSIGN = 1'b1; bOFFSET = 4'd1;
        step("wrap");
        check("wrap.pc", int'(PC), MOD - 1);
        step("wrap_halt");
        check("wrap_halt.flag", int'(halt), 1);

        // Nested call/return
        do_restart();
        for (int i = 0; i < 5; i++) step("to5");
        call_en = 1'b1; jump_tgt = 10'd20;
        step("call1");
        check("call1.pc", int'(PC), 20);
        call_en = 1'b1; jump_tgt = 10'd40;
        step("call2");
        check("call2.cnt", int'(ras_cnt), 2);
        ret_en = 1'b1;
        step("ret1");
        check("ret1.pc", int'(PC), 21);
        ret_en = 1'b1;
        step("ret2");
        check("ret2.pc", int'(PC), 6);
        check("ret2.cnt", int'(ras_cnt), 0);

        // Overflow, underflow, illegal call+ret
        do_restart();
        for (int i = 0; i < 4; i++) begin
            call_en = 1'b1; jump_tgt = PC_W'(8 * (i + 1));
            step("call_n");
        end
        call_en = 1'b1; jump_tgt = 10'd50;
        step("call_ovf");
        check("ovf.fault", int'(fault), 1);
        check("ovf.pc", int'(PC), 32);
        check("ovf.cnt", int'(ras_cnt), 4);
        do_restart();
        ret_en = 1'b1;
        step("ret_unf");
        check("unf.fault", int'(fault), 1);
        do_restart();
        call_en = 1'b1; ret_en = 1'b1; jump_tgt = 10'd30;
        step("callret");
        check("callret.fault", int'(fault), 1);
        check("callret.pc", int'(PC), 0);

        // Stall
        do_restart();
        step("pre_stall");
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1; branch_en = 1'b1; bOFFSET = 4'd7;
            step("stall");
            check("stall.pc", int'(PC), 1);
        end

        // Asynchronous reset in the middle of a call cycle
        step("pre_rst");
        call_en = 1'b1; jump_tgt = 10'd33;
        #2;
        init_n = 1'b0;
        #1;
        model_reset();
        check("async.pc", int'(PC), 0);
        check("async.cnt", int'(ras_cnt), 0);
        #2;
        init_n = 1'b1;
        idle_inputs();
        step("post_rst");

        // restart beats stall
        for (int i = 0; i < 3; i++) step("adv");
        restart = 1'b1; stall = 1'b1;
        step("rst_stall");
        check("rst_stall.pc", int'(PC), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            restart   = ($urandom_range(0, 99) < 3);
            stall     = ($urandom_range(0, 99) < 10);
            ret_en    = ($urandom_range(0, 99) < 15);
            call_en   = ($urandom_range(0, 99) < 18);
            jump_en   = ($urandom_range(0, 99) < 10);
            branch_en = ($urandom_range(0, 99) < 35);
            bSIGN     = 1'($urandom_range(0, 1));
            bOFFSET   = OFF_W'($urandom_range(0, (1 << OFF_W) - 1));
            jump_tgt  = ($urandom_range(0, 9) == 0) ? PC_W'($urandom_range(0, MOD - 1))
                                                    : PC_W'($urandom_range(0, 66));
            if ((m_halt || m_fault) && $urandom_range(0, 3) == 0) restart = 1'b1;
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
